// File: rtl/soc_reset_sequencer.sv
// Staged SoC reset release with debounced key and re-sequence counter.
// Optional watchdog re-sequence enabled by defining SOC_RESET_SEQ_WDT_EN.
module soc_reset_sequencer #(
  parameter int NUM_DOMAINS     = 2,
  parameter int CNT_WIDTH       = 16,
  parameter int POR_CYCLES      = 256,
  parameter int STAGE_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int WDT_CYCLES      = 65535
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   key_n,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   done_o,
  output logic [7:0]             seq_count,
  output logic                   wdt_fired_o
);

  localparam int IDX_W =
    (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_WIDTH-1:0] POR_LAST =
    CNT_WIDTH'(POR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STG_LAST =
    CNT_WIDTH'(STAGE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   key_q, key_d;
  logic [CNT_WIDTH-1:0]   deb_q, deb_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [7:0]             seq_q, seq_d;

  logic press;
  logic wdt_to;
  logic wdt_fired;
  logic trig;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    key_d   = key_q;
    deb_d   = '0;
    if (sync2_q != key_q) begin
      if (deb_q == DEB_LAST) begin
        key_d = sync2_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  // press fires on the very edge the stable key falls
  assign press = key_q & ~key_d;
  assign trig  = press | wdt_to;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      key_q   <= 1'b1;
      deb_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      key_q   <= key_d;
      deb_q   <= deb_d;
    end
  end

`ifdef SOC_RESET_SEQ_WDT_EN
  logic [CNT_WIDTH-1:0] wdt_q, wdt_d;
  logic                 fired_q, fired_d;

  localparam logic [CNT_WIDTH-1:0] WDT_LAST =
    CNT_WIDTH'(WDT_CYCLES - 1);

  always_comb begin
    wdt_d  = '0;
    wdt_to = 1'b0;
    if (state_q == RUN) begin
      if (wdt_kick) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_LAST) begin
        wdt_to = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
    fired_d = fired_q | wdt_to;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fired_q <= fired_d;
    end
  end

  assign wdt_fired = fired_q;
`else
  logic unused_wdt;

  assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_to     = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (key_q && cnt_q == POR_LAST) begin
          state_d = STAGE;
        end
      end
      STAGE: begin
        if (cnt_q == STG_LAST && idx_q == IDX_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
    if (trig) begin
      state_d = HOLD;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    rst_d  = rst_q;
    done_d = done_q;
    seq_d  = seq_q;
    unique case (state_q)
      HOLD: begin
        rst_d  = '1;
        done_d = 1'b0;
        idx_d  = '0;
        // a held key keeps the count parked at zero
        if (!key_q || cnt_q == POR_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STAGE: begin
        if (cnt_q == STG_LAST) begin
          cnt_d        = '0;
          rst_d[idx_q] = 1'b0;
          if (idx_q == IDX_LAST) begin
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     cnt_d = '0;
      default: cnt_d = '0;
    endcase
    if (trig) begin
      cnt_d  = '0;
      idx_d  = '0;
      rst_d  = '1;
      done_d = 1'b0;
      if (seq_q != 8'hFF) begin
        seq_d = seq_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
      seq_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      rst_q  <= rst_d;
      done_q <= done_d;
      seq_q  <= seq_d;
    end
  end

  always_comb begin
    rst_o       = rst_q;
    done_o      = done_q;
    seq_count   = seq_q;
    wdt_fired_o = wdt_fired;
  end

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer: vector table plus
// hand-written key, reset and watchdog sequences.
module tb_soc_reset_sequencer;

  localparam int ND = 3;

  logic          clock;
  logic          reset_n;
  logic          key_n;
  logic          wdt_kick;
  logic [ND-1:0] rst_o;
  logic          done_o;
  logic [7:0]    seq_count;
  logic          wdt_fired_o;

  int checks   = 0;
  int failures = 0;

  soc_reset_sequencer #(
    .NUM_DOMAINS     (ND),
    .CNT_WIDTH       (16),
    .POR_CYCLES      (8),
    .STAGE_CYCLES    (4),
    .DEBOUNCE_CYCLES (4),
    .WDT_CYCLES      (32)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .wdt_kick    (wdt_kick),
    .rst_o       (rst_o),
    .done_o      (done_o),
    .seq_count   (seq_count),
    .wdt_fired_o (wdt_fired_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         edge_n;
    logic       key;
    logic [2:0] rst;
    logic       done;
    logic [7:0] seq;
  } vec_t;

  vec_t tbl[8];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  // call with reset_n just released; edge 1 is next posedge
  task automatic run_table(input string tag);
    int cur;
    cur = 0;
    for (int v = 0; v < 8; v++) begin
      key_n = tbl[v].key;
      while (cur < tbl[v].edge_n) begin
        tick(1);
        cur++;
      end
      chk({tag, "_rst"},  32'(rst_o),     32'(tbl[v].rst));
      chk({tag, "_done"}, 32'(done_o),    32'(tbl[v].done));
      chk({tag, "_seq"},  32'(seq_count), 32'(tbl[v].seq));
    end
  endtask

  task automatic press_only();
    key_n = 1'b0;
    tick(6);
  endtask

  initial begin
    tbl[0] = '{1,  1'b1, 3'b111, 1'b0, 8'd0};
    tbl[1] = '{11, 1'b1, 3'b111, 1'b0, 8'd0};
    tbl[2] = '{12, 1'b1, 3'b110, 1'b0, 8'd0};
    tbl[3] = '{15, 1'b1, 3'b110, 1'b0, 8'd0};
    tbl[4] = '{16, 1'b1, 3'b100, 1'b0, 8'd0};
    tbl[5] = '{19, 1'b1, 3'b100, 1'b0, 8'd0};
    tbl[6] = '{20, 1'b1, 3'b000, 1'b1, 8'd0};
    tbl[7] = '{25, 1'b1, 3'b000, 1'b1, 8'd0};

    reset_n  = 1'b0;
    key_n    = 1'b1;
    wdt_kick = 1'b0;
    tick(3);
    chk("reset_rst",   32'(rst_o),       32'h7);
    chk("reset_done",  32'(done_o),      32'h0);
    chk("reset_seq",   32'(seq_count),   32'h0);
    chk("reset_fired", 32'(wdt_fired_o), 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    run_table("seq1");

    // short glitch must be filtered
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(10);
    chk("glitch_rst",  32'(rst_o),     32'h0);
    chk("glitch_done", 32'(done_o),    32'h1);
    chk("glitch_seq",  32'(seq_count), 32'h0);

    // long press: held in reset while key is down
    key_n = 1'b0;
    tick(8);
    chk("press_rst",  32'(rst_o),     32'h7);
    chk("press_done", 32'(done_o),    32'h0);
    chk("press_seq",  32'(seq_count), 32'h1);
    tick(12);
    chk("held_rst", 32'(rst_o), 32'h7);
    key_n = 1'b1;
    tick(17);
    chk("rel17_rst", 32'(rst_o), 32'h7);
    tick(1);
    chk("rel18_rst", 32'(rst_o), 32'h6);
    tick(7);
    chk("rel25_rst",  32'(rst_o),  32'h4);
    chk("rel25_done", 32'(done_o), 32'h0);
    tick(1);
    chk("rel26_rst",  32'(rst_o),     32'h0);
    chk("rel26_done", 32'(done_o),    32'h1);
    chk("rel26_seq",  32'(seq_count), 32'h1);

    // second press, then reset_n mid-STAGE with idx=1
    press_only();
    chk("press2_seq", 32'(seq_count), 32'h2);
    chk("press2_rst", 32'(rst_o),     32'h7);
    key_n = 1'b1;
    tick(19);
    chk("stage1_rst", 32'(rst_o), 32'h6);
    reset_n = 1'b0;
    #1;
    chk("async_rst",  32'(rst_o),     32'h7);
    chk("async_done", 32'(done_o),    32'h0);
    chk("async_seq",  32'(seq_count), 32'h0);
    tick(2);
    @(negedge clock);
    reset_n = 1'b1;
    run_table("seq2");

    // watchdog: kicked every 16 cycles, then starved
    for (int k = 0; k < 5; k++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(15);
    end
    chk("kick_rst",   32'(rst_o),       32'h0);
    chk("kick_seq",   32'(seq_count),   32'h0);
    chk("kick_fired", 32'(wdt_fired_o), 32'h0);
    tick(16);
    chk("wdt31_rst",   32'(rst_o),       32'h0);
    chk("wdt31_fired", 32'(wdt_fired_o), 32'h0);
    tick(1);
`ifdef SOC_RESET_SEQ_WDT_EN
    chk("wdt32_rst",   32'(rst_o),       32'h7);
    chk("wdt32_done",  32'(done_o),      32'h0);
    chk("wdt32_seq",   32'(seq_count),   32'h1);
    chk("wdt32_fired", 32'(wdt_fired_o), 32'h1);
`else
    chk("wdt32_rst",   32'(rst_o),       32'h0);
    chk("wdt32_done",  32'(done_o),      32'h1);
    chk("wdt32_seq",   32'(seq_count),   32'h0);
    chk("wdt32_fired", 32'(wdt_fired_o), 32'h0);
`endif

    reset_n = 1'b0;
    tick(2);
    chk("clr_fired", 32'(wdt_fired_o), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // saturation of the re-sequence counter
    for (int i = 0; i < 256; i++) begin
      press_only();
      chk("sat_seq", 32'(seq_count),
          (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      chk("sat_rst", 32'(rst_o), 32'h7);
      key_n = 1'b1;
      tick(6);
    end
    tick(20);
    chk("sat_done", 32'(done_o),    32'h1);
    chk("sat_rst0", 32'(rst_o),     32'h0);
    chk("sat_fin",  32'(seq_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
